// File: rtl/cache_with_miss_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with a miss
// controller that fetches a whole line word by word on a read miss and
// forwards every store to external memory.
module cache_with_miss_controller #(
  parameter int INDEX_BITS   = 5,
  parameter int BLOCK_OFFSET = 6,
  parameter int WORD_SIZE    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_addr,
  input  logic [WORD_SIZE-1:0] i_data_in,
  output logic [WORD_SIZE-1:0] o_data_out,
  input  logic                 i_wr,
  input  logic                 i_re,
  input  logic                 i_enable,
  output logic                 o_stall,
  output logic [31:0]          o_ext_addr,
  output logic [WORD_SIZE-1:0] o_ext_data_out,
  input  logic [WORD_SIZE-1:0] i_ext_data_in,
  output logic                 o_ext_re,
  output logic                 o_ext_wr,
  input  logic                 i_ext_ack
);

  localparam int CACHE_LINES = 2**INDEX_BITS;
  localparam int WSEL_BITS   = BLOCK_OFFSET - 2;
  localparam int WORDS       = 2**WSEL_BITS;
  localparam int TAG_BITS    = 32 - INDEX_BITS - BLOCK_OFFSET;
  localparam int BASE_BITS   = 32 - BLOCK_OFFSET;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    WDONE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CACHE_LINES-1:0] r_valid;
  logic [TAG_BITS-1:0]    r_tag  [CACHE_LINES];
  logic [WORD_SIZE-1:0]   r_data [CACHE_LINES*WORDS];
  logic [WORD_SIZE-1:0]   r_buf  [WORDS];
  logic [WSEL_BITS-1:0]   r_cnt;
  logic [BASE_BITS-1:0]   r_base;
  logic [29:0]            r_waddr;
  logic [WORD_SIZE-1:0]   r_wdata;

  // Field extraction for the live request, the latched store and the fill line.
  logic [INDEX_BITS-1:0]  w_idx, w_widx, w_bidx;
  logic [TAG_BITS-1:0]    w_tag, w_wtag, w_btag;
  logic [WSEL_BITS-1:0]   w_wsel, w_wwsel;
  logic                   w_hit, w_whit, w_active, w_fill_done, w_write_ack;
  logic                   w_unused;

  assign w_idx   = i_addr[INDEX_BITS+BLOCK_OFFSET-1:BLOCK_OFFSET];
  assign w_tag   = i_addr[31:INDEX_BITS+BLOCK_OFFSET];
  assign w_wsel  = i_addr[BLOCK_OFFSET-1:2];
  assign w_widx  = r_waddr[INDEX_BITS+BLOCK_OFFSET-3:BLOCK_OFFSET-2];
  assign w_wtag  = r_waddr[29:INDEX_BITS+BLOCK_OFFSET-2];
  assign w_wwsel = r_waddr[WSEL_BITS-1:0];
  assign w_bidx  = r_base[INDEX_BITS-1:0];
  assign w_btag  = r_base[BASE_BITS-1:INDEX_BITS];
  assign w_unused = ^i_addr[1:0];

  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_whit = r_valid[w_widx] && (r_tag[w_widx] == w_wtag);

  // Reset is folded in so that every strobe is quiet while rst is held low.
  assign w_active    = i_enable & i_rst;
  assign w_fill_done = w_active && (r_state == FILL) && i_ext_ack &&
                       (r_cnt == {WSEL_BITS{1'b1}});
  assign w_write_ack = w_active && (r_state == WRITE) && i_ext_ack;

  // Load data comes straight from the addressed word, hit or not.
  assign o_data_out = r_data[{w_idx, w_wsel}];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Valid bits, fill counter and latched request fields.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_active && i_wr) begin
            r_waddr <= i_addr[31:2];
            r_wdata <= i_data_in;
          end
          if (w_active && !i_wr && i_re && !w_hit) begin
            r_base <= i_addr[31:BLOCK_OFFSET];
          end
        end
        FILL: begin
          if (w_active && i_ext_ack) begin
            r_cnt <= r_cnt + WSEL_BITS'(1);
          end
          if (w_fill_done) begin
            r_valid[w_bidx] <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line buffer capture, line install on the last fill word, store-hit update.
  always_ff @(posedge i_clk) begin
    if (w_active && (r_state == FILL) && i_ext_ack) begin
      r_buf[r_cnt] <= i_ext_data_in;
    end
    if (w_fill_done) begin
      r_tag[w_bidx] <= w_btag;
      for (int i = 0; i < WORDS; i++) begin
        r_data[{w_bidx, WSEL_BITS'(i)}] <= (i == WORDS-1) ? i_ext_data_in
                                                           : r_buf[WSEL_BITS'(i)];
      end
    end
    if (w_write_ack && w_whit) begin
      r_data[{w_widx, w_wwsel}] <= r_wdata;
    end
  end

  // Next-state logic; dropping enable aborts any transfer back to IDLE.
  always_comb begin
    w_next = r_state;
    if (!w_active) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_wr) begin
            w_next = WRITE;
          end else if (i_re && !w_hit) begin
            w_next = FILL;
          end else begin
            w_next = IDLE;
          end
        end
        FILL: begin
          if (w_fill_done) begin
            w_next = IDLE;
          end else begin
            w_next = FILL;
          end
        end
        WRITE: begin
          if (i_ext_ack) begin
            w_next = WDONE;
          end else begin
            w_next = WRITE;
          end
        end
        WDONE:   w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Core stall and external bus outputs.
  always_comb begin
    o_stall        = 1'b0;
    o_ext_re       = 1'b0;
    o_ext_wr       = 1'b0;
    o_ext_addr     = 32'd0;
    o_ext_data_out = '0;
    if (w_active) begin
      case (r_state)
        IDLE: o_stall = i_wr | (i_re & ~w_hit);
        FILL: begin
          o_stall    = 1'b1;
          o_ext_re   = 1'b1;
          o_ext_addr = {r_base, r_cnt, 2'b00};
        end
        WRITE: begin
          o_stall        = 1'b1;
          o_ext_wr       = 1'b1;
          o_ext_addr     = {r_waddr, 2'b00};
          o_ext_data_out = r_wdata;
        end
        default: o_stall = 1'b0;
      endcase
    end else begin
      o_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_with_miss_controller.sv
// Self-checking bench: a transaction-level model of the cache and the
// external memory predicts every output each cycle; directed scenarios add
// literal expectations on top, followed by a randomized request stream.
module tb_cache_with_miss_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'd0, data_in = 32'd0, ext_data_in = 32'd0;
  logic        wr = 1'b0, re = 1'b0, enable = 1'b0, ext_ack = 1'b0;
  logic [31:0] data_out, ext_addr, ext_data_out;
  logic        stall, ext_re, ext_wr;

  cache_with_miss_controller dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_data_in(data_in),
    .o_data_out(data_out), .i_wr(wr), .i_re(re), .i_enable(enable),
    .o_stall(stall), .o_ext_addr(ext_addr), .o_ext_data_out(ext_data_out),
    .i_ext_data_in(ext_data_in), .o_ext_re(ext_re), .o_ext_wr(ext_wr),
    .i_ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- external memory ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] salt = 32'd0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem.exists(wa)) return mem[wa];
    return 32'hA000_0000 + 32'(a[5:2]) + (wa >> 6) * salt;
  endfunction

  // ---------------- cache model (transactions) ----------------
  // kind: 0 none pending, 1 line fetch, 2 store on bus, 3 store retiring
  bit          mvalid [32];
  logic [20:0] mtag   [32];
  logic [31:0] mline  [32][16];
  logic [31:0] linebuf [16];
  int          kind = 0;
  int          done = 0;
  logic [31:0] fill_base = 32'd0, st_addr = 32'd0, st_data = 32'd0;

  function automatic bit mhit(input logic [31:0] a);
    return mvalid[a[10:6]] && (mtag[a[10:6]] == a[31:11]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    kind = 0;
    done = 0;
  endtask

  task automatic model_edge();
    logic [31:0] wa;
    if (!rst) return;
    if (!enable) begin
      kind = 0;
      return;
    end
    case (kind)
      0: begin
        if (wr) begin
          kind = 2; st_addr = addr; st_data = data_in;
        end else if (re && !mhit(addr)) begin
          kind = 1; fill_base = {addr[31:6], 6'd0}; done = 0;
        end
      end
      1: if (ext_ack) begin
        linebuf[done] = mem_read(fill_base + 32'(4 * done));
        done++;
        if (done == 16) begin
          mvalid[fill_base[10:6]] = 1'b1;
          mtag[fill_base[10:6]]   = fill_base[31:11];
          for (int i = 0; i < 16; i++) mline[fill_base[10:6]][i] = linebuf[i];
          kind = 0;
        end
      end
      2: if (ext_ack) begin
        wa = {st_addr[31:2], 2'b00};
        mem[wa] = st_data;
        if (mhit(wa)) mline[wa[10:6]][wa[5:2]] = st_data;
        kind = 3;
      end
      default: kind = 0;
    endcase
  endtask

  // ---------------- checking ----------------
  logic        e_stall;
  logic [31:0] s_addr, s_edo, s_dout;
  logic        s_stall, s_re, s_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    bit          act;
    logic [31:0] e_addr, e_edo;
    act     = rst && enable;
    e_stall = act && ((kind == 0) ? (wr || (re && !mhit(addr))) : (kind != 3));
    e_addr  = !act ? 32'd0 : (kind == 1) ? fill_base + 32'(4 * done)
            : (kind == 2) ? {st_addr[31:2], 2'b00} : 32'd0;
    e_edo   = (act && kind == 2) ? st_data : 32'd0;
    s_stall = stall; s_re = ext_re; s_wr = ext_wr;
    s_addr = ext_addr; s_edo = ext_data_out; s_dout = data_out;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("ext_re", 32'(ext_re), 32'(act && kind == 1));
    chk("ext_wr", 32'(ext_wr), 32'(act && kind == 2));
    chk("ext_addr", ext_addr, e_addr);
    chk("ext_data_out", ext_data_out, e_edo);
    if (act && kind == 0 && re && !wr && mhit(addr))
      chk("data_out", data_out, mline[addr[10:6]][addr[5:2]]);
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic step(input logic en, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic ack, input logic rst_v);
    enable = en; re = r; wr = w; addr = a; data_in = d; ext_ack = ack; rst = rst_v;
    if (!rst_v) model_reset();
    #1;
    ext_data_in = mem_read(ext_addr);
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [31:0] seen_addr [$];

  // Holds a load until stall drops; ack on every p-th cycle of the request.
  task automatic run_read(input logic [31:0] a, input int p, output int stalls);
    bit fin;
    fin = 1'b0; stalls = 0; seen_addr.delete();
    for (int c = 0; c < 400; c++) begin
      step(1'b1, 1'b1, 1'b0, a, 32'd0, (c % p) == (p - 1), 1'b1);
      if (s_re) seen_addr.push_back(s_addr);
      if (!s_stall) begin fin = 1'b1; break; end
      stalls++;
    end
    if (!fin) chk("read_timeout", 32'd1, 32'd0);
  endtask

  // Holds a store until stall drops; ext_ack asserted on cycle index ack_at.
  task automatic run_write(input logic [31:0] a, input logic [31:0] d,
                           input int ack_at, output int stalls,
                           output logic [31:0] wa, output logic [31:0] wd);
    bit fin;
    fin = 1'b0; stalls = 0; wa = 32'd0; wd = 32'd0;
    for (int c = 0; c < 400; c++) begin
      step(1'b1, 1'b0, 1'b1, a, d, c == ack_at, 1'b1);
      if (s_wr) begin wa = s_addr; wd = s_edo; end
      if (!s_stall) begin fin = 1'b1; break; end
      stalls++;
    end
    if (!fin) chk("write_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] tags [3];
    logic [31:0] idxs [3];
    tags[0] = 32'd1; tags[1] = 32'd2; tags[2] = 32'd5;
    idxs[0] = 32'd0; idxs[1] = 32'd1; idxs[2] = 32'd31;
    return (tags[$urandom_range(2)] << 11) | (idxs[$urandom_range(2)] << 6) |
           (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
  endfunction

  initial begin
    int          st;
    logic [31:0] wa, wd;
    bit          prev_stall;
    logic        r_en, r_re, r_wr, r_rst, r_ack;
    logic [31:0] r_a, r_d;

    model_reset();
    // Reset: nothing asserted while rst is low, even for a missing load.
    step(1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 1'b0);
    chk("reset_stall", 32'(s_stall), 32'd0);
    chk("reset_ext_re", 32'(s_re), 32'd0);
    run_read(32'h100, 1, st);
    chk("post_reset_miss_stalls", 32'(st), 32'd17);

    // Read miss fill with single-cycle ack.
    run_read(32'h0000_1048, 1, st);
    chk("fill_stalls", 32'(st), 32'd17);
    chk("fill_words", 32'(seen_addr.size()), 32'd16);
    if (seen_addr.size() == 16) begin
      chk("fill_first_addr", seen_addr[0], 32'h1040);
      chk("fill_second_addr", seen_addr[1], 32'h1044);
      chk("fill_last_addr", seen_addr[15], 32'h107C);
    end
    chk("fill_data", s_dout, 32'hA000_0002);
    chk("fill_no_more_re", 32'(s_re), 32'd0);

    // Ack every third cycle: evict with another tag, then refill the line.
    run_read(32'h0000_3048, 3, st);
    chk("slow_fill_stalls", 32'(st), 32'd48);
    run_read(32'h0000_1048, 3, st);
    chk("slow_refill_stalls", 32'(st), 32'd48);
    chk("slow_refill_data", s_dout, 32'hA000_0002);
    run_read(32'h0000_107C, 1, st);
    chk("slow_refill_word15_stalls", 32'(st), 32'd0);
    chk("slow_refill_word15", s_dout, 32'hA000_000F);

    // Write hit, ack on the second WRITE cycle.
    run_write(32'h1044, 32'hDEAD_BEEF, 2, st, wa, wd);
    chk("wr_hit_stalls", 32'(st), 32'd3);
    chk("wr_hit_ext_addr", wa, 32'h1044);
    chk("wr_hit_ext_data", wd, 32'hDEAD_BEEF);
    run_read(32'h1044, 1, st);
    chk("wr_hit_read_stalls", 32'(st), 32'd0);
    chk("wr_hit_read_data", s_dout, 32'hDEAD_BEEF);

    // Write miss: no allocate, the later load misses and sees memory.
    run_write(32'h2000, 32'h1234_5678, 1, st, wa, wd);
    chk("wr_miss_stalls", 32'(st), 32'd2);
    chk("wr_miss_ext_addr", wa, 32'h2000);
    run_read(32'h2000, 1, st);
    chk("wr_miss_read_stalls", 32'(st), 32'd17);
    chk("wr_miss_read_data", s_dout, 32'h1234_5678);

    // Abort by enable after 5 acks, then a full refill from word 0.
    step(1'b1, 1'b1, 1'b0, 32'h5000, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h5000, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h5000, 32'd0, 1'b1, 1'b1);
    chk("abort_ext_re", 32'(s_re), 32'd0);
    chk("abort_stall", 32'(s_stall), 32'd0);
    run_read(32'h5000, 1, st);
    chk("abort_refill_stalls", 32'(st), 32'd17);
    if (seen_addr.size() > 0) chk("abort_refill_first", seen_addr[0], 32'h5000);

    // Abort by reset mid-fill: every line is invalid afterwards.
    step(1'b1, 1'b1, 1'b0, 32'h6000, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h6000, 32'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h6000, 32'd0, 1'b1, 1'b0);
    chk("rst_abort_ext_re", 32'(s_re), 32'd0);
    chk("rst_abort_stall", 32'(s_stall), 32'd0);
    run_read(32'h1044, 1, st);
    chk("rst_refill_stalls", 32'(st), 32'd17);
    chk("rst_refill_data", s_dout, 32'hDEAD_BEEF);

    // Randomized request stream; requests change only when not stalled.
    salt = 32'h0001_0001;
    prev_stall = 1'b0;
    r_en = 1'b1; r_re = 1'b0; r_wr = 1'b0; r_a = 32'd0; r_d = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      if (!prev_stall) begin
        case ($urandom_range(9))
          0, 1:       begin r_en = 1'b1; r_re = 1'b0; r_wr = 1'b0; end
          2, 3, 4, 5: begin r_en = 1'b1; r_re = 1'b1; r_wr = 1'b0; end
          6, 7, 8:    begin r_en = 1'b1; r_re = 1'($urandom_range(1)); r_wr = 1'b1; end
          default:    begin r_en = 1'b0; r_re = 1'($urandom_range(1)); r_wr = 1'($urandom_range(1)); end
        endcase
        r_a = rand_addr();
        r_d = $urandom;
      end else if ($urandom_range(49) == 0) begin
        r_en = 1'b0;
      end
      r_rst = ($urandom_range(699) == 0) ? 1'b0 : 1'b1;
      r_ack = ($urandom_range(2) == 0) ? 1'b1 : 1'b0;
      step(r_en, r_re, r_wr, r_a, r_d, r_ack, r_rst);
      prev_stall = e_stall;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
